// File: rtl/seq_subtractor_64bit.sv
// seq_subtractor_64bit: chunk-serial D = A - B - Bin with borrow-out, one CHUNK slice per clock,
// valid/ready handshakes on both sides.
module seq_subtractor_64bit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
    output logic             B_Out
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, d_q, d_d;
    logic             brw_q, brw_d, bout_q, bout_d;
    logic [CHUNK:0]   diff;
    logic             last;
    // One extra bit on the slice difference captures the chunk borrow.
    assign diff = {1'b0, a_q[cnt_q*CHUNK +: CHUNK]} - {1'b0, b_q[cnt_q*CHUNK +: CHUNK]}
                - {{CHUNK{1'b0}}, brw_q};
    assign last = (cnt_q == CW'(NCHUNK - 1));
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign D     = d_q;
    assign B_Out = bout_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        d_d     = d_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = A;
                b_d     = B;
                brw_d   = Bin;
                cnt_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                d_d[cnt_q*CHUNK +: CHUNK] = diff[CHUNK-1:0];
                brw_d = diff[CHUNK];
                cnt_d = cnt_q + 1'b1;
                if (last) begin
                    bout_d  = diff[CHUNK];
                    state_d = DONE;
                end
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
        end
    end
endmodule

// File: doc/seq_subtractor_64bit.md
Name: seq_subtractor_64bit

Overview:
- Multi-cycle, chunk-serial 64-bit subtractor. It is the inverse-direction companion to the team's 64-bit adders.
- Computes D = A - B - Bin, with borrow-out, one CHUNK-bit slice per clock.
- Uses valid/ready handshakes on both input and output, so it can sit between a stimulus source and a checker in the adder verification environment.
- Trades latency for a short critical path: a CHUNK-bit borrow chain instead of a 64-bit one.

Parameters:
- WIDTH, 64, operand width in bits.
- CHUNK, 16, bits processed per cycle. WIDTH must be an integer multiple of CHUNK.
- NCHUNK = WIDTH/CHUNK, derived (local); default 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block is idle and can accept operands.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- Bin  input  1  borrow-in.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts result.
- D  output  WIDTH  difference, (A - B - Bin) mod 2^WIDTH.
- B_Out  output  1  borrow-out: 1 iff A < B + Bin, unsigned.

Behaviour:
- Reset is asynchronous on rst_n low and takes effect immediately.
  - State goes to IDLE; chunk counter = 0; operand and result registers = 0; borrow register = 0.
  - Output values during and after reset: D = 0, B_Out = 0, out_valid = 0, in_ready = 1 (decoded from IDLE).
- States: IDLE, CALC, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- IDLE:
  - On a clock edge with in_valid & in_ready: capture A, B and Bin into internal registers; counter = 0; go to CALC.
  - Otherwise stay in IDLE.
- CALC:
  - Each edge computes {borrow, D[k*CHUNK +: CHUNK]} = A_reg slice k - B_reg slice k - borrow, where k = counter and the initial borrow is the captured Bin.
  - Then increment the counter.
  - On the edge processing k = NCHUNK-1: B_Out = final borrow; go to DONE.
- DONE:
  - D and B_Out are held stable while out_ready = 0.
  - On an edge with out_ready = 1: go to IDLE. D and B_Out keep their last value; they are not cleared.
- Latency:
  - Operands accepted at edge 0; out_valid high after edge NCHUNK (4 with defaults).
  - Earliest next acceptance is the edge following the output handshake. Throughput with no back-pressure is one result per NCHUNK+2 cycles.
- If out_ready is already high when out_valid rises, the handshake completes on the next edge; there is no zero-cycle pass-through.
- in_valid outside IDLE is ignored. Changes on A, B and Bin after acceptance have no effect on the result.
- out_ready outside DONE is ignored.
- Partial D bits are updated during CALC but are only defined as valid while out_valid = 1.
- Arithmetic:
  - Unsigned throughout; wrap-around is modulo 2^WIDTH.
  - A = B with Bin = 0 gives D = 0, B_Out = 0.
  - A = B with Bin = 1 gives D = all ones, B_Out = 1.
- Reset asserted mid-CALC or mid-DONE aborts the operation with no output handshake; the block resumes in IDLE.

Test Plan:
- A=5, B=3, Bin=0, out_ready=1 -> out_valid high 4 cycles after acceptance; D=2, B_Out=0; in_ready returns high the cycle after the handshake.
- A=0, B=1, Bin=0 -> D=0xFFFF_FFFF_FFFF_FFFF, B_Out=1. Also A=B=0x1234_5678_9ABC_DEF0 with Bin=1 -> D=all ones, B_Out=1.
- Borrow across chunk boundaries:
  - A=0x0001_0000_0000_0000, B=1, Bin=0 -> D=0x0000_FFFF_FFFF_FFFF, B_Out=0.
  - A=0x0000_0000_0001_0000, B=0, Bin=1 -> D=0x0000_0000_0000_FFFF.
- Back-pressure and input isolation:
  - Hold out_ready=0 for 10 cycles after out_valid -> D and B_Out stable, in_ready=0.
  - A new in_valid pulse during that window is ignored; the accepted result is the original one.
- Reset mid-operation: assert rst_n=0 two cycles into CALC -> out_valid=0, D=0, B_Out=0 immediately, in_ready=1. A subsequent 9-7-0 transaction yields D=2.
- Random regression: 10k random A, B, Bin with random out_ready stalls -> every result matches the golden expression {B_Out, D} = {1'b0,A} - {1'b0,B} - Bin, with the borrow taken from bit WIDTH; exactly one output handshake per accepted input.
